// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: pixel-enable divider, H/V timing counters, band
// counters and a one-tick registered output stage with frame-synchronous mode latch.
module vga_pattern_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BAND_W   = 80,
    parameter int BAND_H   = 60
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] iMode,
    input  logic [2:0] iSolidColor,
    input  logic       iEnable,
    output logic       oVGA_R,
    output logic       oVGA_G,
    output logic       oVGA_B,
    output logic       oHorizontal_Sync,
    output logic       oVertical_Sync,
    output logic       oFrameStart,
    output logic [9:0] oCurrentCol,
    output logic [9:0] oCurrentRow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [9:0]       col_q, col_d, row_q, row_d;
    logic [9:0]       col_sub_q, col_sub_d, col_band_q, col_band_d;
    logic [9:0]       row_sub_q, row_sub_d, row_band_q, row_band_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             hs_q, hs_d, vs_q, vs_d, fs_q;

    logic tick, col_wrap, row_wrap, at_origin, active;

    assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
    assign col_wrap  = (col_q == 10'(H_TOTAL - 1));
    assign row_wrap  = (row_q == 10'(V_TOTAL - 1));
    assign at_origin = (col_q == 10'd0) && (row_q == 10'd0);
    assign active    = (col_q < 10'(H_ACTIVE)) && (row_q < 10'(V_ACTIVE));

    always_comb begin
        col_d      = col_wrap ? 10'd0 : col_q + 10'd1;
        row_d      = row_q;
        col_sub_d  = col_sub_q + 10'd1;
        col_band_d = col_band_q;
        row_sub_d  = row_sub_q;
        row_band_d = row_band_q;

        if (col_wrap) begin
            col_sub_d  = 10'd0;
            col_band_d = 10'd0;
            if (row_wrap) begin
                row_d      = 10'd0;
                row_sub_d  = 10'd0;
                row_band_d = 10'd0;
            end else begin
                row_d = row_q + 10'd1;
                if (row_sub_q == 10'(BAND_H - 1)) begin
                    row_sub_d  = 10'd0;
                    row_band_d = row_band_q + 10'd1;
                end else begin
                    row_sub_d = row_sub_q + 10'd1;
                end
            end
        end else if (col_sub_q == 10'(BAND_W - 1)) begin
            col_sub_d  = 10'd0;
            col_band_d = col_band_q + 10'd1;
        end
    end

    // The mode sampled at the origin also colours that origin pixel, so the
    // whole new frame is drawn in one mode.
    assign mode_d = at_origin ? iMode : mode_q;

    always_comb begin
        rgb_d = 3'b000;
        if (active && iEnable) begin
            case (mode_d)
                2'd0:    rgb_d = iSolidColor;
                2'd1:    rgb_d = col_band_q[2:0];
                2'd2:    rgb_d = row_band_q[2:0];
                default: rgb_d = (col_band_q[0] ^ row_band_q[0]) ? 3'b111 : 3'b000;
            endcase
        end
        hs_d = !((col_q >= 10'(H_ACTIVE + H_FP)) && (col_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
        vs_d = !((row_q >= 10'(V_ACTIVE + V_FP)) && (row_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            col_sub_q  <= '0;
            col_band_q <= '0;
            row_sub_q  <= '0;
            row_band_q <= '0;
            mode_q     <= '0;
            rgb_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            fs_q       <= 1'b0;
        end else begin
            // Frame-start pulse is one Clock wide even when ticks are sparse.
            fs_q <= 1'b0;
            if (tick) begin
                div_q      <= '0;
                col_q      <= col_d;
                row_q      <= row_d;
                col_sub_q  <= col_sub_d;
                col_band_q <= col_band_d;
                row_sub_q  <= row_sub_d;
                row_band_q <= row_band_d;
                mode_q     <= mode_d;
                rgb_q      <= rgb_d;
                hs_q       <= hs_d;
                vs_q       <= vs_d;
                fs_q       <= at_origin;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign oVGA_R           = rgb_q[2];
    assign oVGA_G           = rgb_q[1];
    assign oVGA_B           = rgb_q[0];
    assign oHorizontal_Sync = hs_q;
    assign oVertical_Sync   = vs_q;
    assign oFrameStart      = fs_q;
    assign oCurrentCol      = col_q;
    assign oCurrentRow      = row_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced 80x55 raster (8x6 bands) so
// several full frames fit in a short run.
module tb_vga_pattern_gen;
    localparam int LIMIT = 20000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] iMode = 2'd0;
    logic [2:0] iSolidColor = 3'b100;
    logic       iEnable = 1'b1;
    logic       oVGA_R, oVGA_G, oVGA_B;
    logic       oHorizontal_Sync, oVertical_Sync, oFrameStart;
    logic [9:0] oCurrentCol, oCurrentRow;

    int checks_total  = 0;
    int checks_passed = 0;

    vga_pattern_gen #(
        .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .BAND_W(8), .BAND_H(6)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iMode(iMode), .iSolidColor(iSolidColor),
        .iEnable(iEnable), .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oHorizontal_Sync(oHorizontal_Sync), .oVertical_Sync(oVertical_Sync),
        .oFrameStart(oFrameStart), .oCurrentCol(oCurrentCol), .oCurrentRow(oCurrentRow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks_total++;
        if (got == exp) begin
            checks_passed++;
            $display("check %-14s got %0d exp %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int rgb();
        return {29'd0, oVGA_R, oVGA_G, oVGA_B};
    endfunction

    // Returns on the negedge right after the pixel (c,r) tick, when the
    // registered outputs describe that pixel.
    task automatic wait_pixel(input int c, input int r);
        int n = 0;
        while (!(oCurrentCol == c && oCurrentRow == r) && n < LIMIT) begin
            @(negedge Clock); n++;
        end
        while ((oCurrentCol == c && oCurrentRow == r) && n < LIMIT) begin
            @(negedge Clock); n++;
        end
        if (n >= LIMIT) chk("timeout_pix", n, 0);
    endtask

    task automatic measure_hsync();
        int n = 0, low = 0, high = 0;
        while (oHorizontal_Sync !== 1'b1 && n < LIMIT) begin @(negedge Clock); n++; end
        while (oHorizontal_Sync !== 1'b0 && n < LIMIT) begin @(negedge Clock); n++; end
        while (oHorizontal_Sync === 1'b0 && n < LIMIT) begin @(negedge Clock); n++; low++; end
        while (oHorizontal_Sync === 1'b1 && n < LIMIT) begin @(negedge Clock); n++; high++; end
        chk("hsync_low", low, 16);
        chk("hsync_period", low + high, 160);
    endtask

    task automatic measure_frame();
        int n = 0, per = 0;
        while (oFrameStart !== 1'b1 && n < LIMIT) begin @(negedge Clock); n++; end
        @(negedge Clock);
        chk("fs_width", int'(oFrameStart), 0);
        per = 1;
        while (oFrameStart !== 1'b1 && per < LIMIT) begin @(negedge Clock); per++; end
        chk("frame_period", per, 8800);
    endtask

    initial begin
        repeat (4) @(negedge Clock);
        chk("rst_col", int'(oCurrentCol), 0);
        chk("rst_row", int'(oCurrentRow), 0);
        chk("rst_rgb", rgb(), 0);
        chk("rst_hs", int'(oHorizontal_Sync), 1);
        chk("rst_vs", int'(oVertical_Sync), 1);
        chk("rst_fs", int'(oFrameStart), 0);
        Reset = 1'b0;

        // Frame 1: solid red, sync geometry
        wait_pixel(5, 3);   chk("solid_5_3", rgb(), 3'b100);
        wait_pixel(67, 3);  chk("hs_67", int'(oHorizontal_Sync), 1);
        wait_pixel(68, 3);  chk("hs_68", int'(oHorizontal_Sync), 0);
                            chk("blank_68_3", rgb(), 0);
        wait_pixel(75, 3);  chk("hs_75", int'(oHorizontal_Sync), 0);
        wait_pixel(76, 3);  chk("hs_76", int'(oHorizontal_Sync), 1);
        wait_pixel(0, 20);  iMode = 2'd1;
        wait_pixel(10, 25); chk("latched_solid", rgb(), 3'b100);
        wait_pixel(79, 49); chk("vs_row49", int'(oVertical_Sync), 1);
        wait_pixel(0, 50);  chk("vs_row50", int'(oVertical_Sync), 0);
        wait_pixel(0, 52);  chk("vs_row52", int'(oVertical_Sync), 1);

        // Frame 2: vertical bars
        wait_pixel(0, 0);   chk("fs_pulse", int'(oFrameStart), 1);
        wait_pixel(8, 10);  chk("bar1", rgb(), 3'b001);
        wait_pixel(9, 10);  chk("fs_low", int'(oFrameStart), 0);
        wait_pixel(16, 10); chk("bar2", rgb(), 3'b010);
        wait_pixel(63, 10); chk("bar7", rgb(), 3'b111);
        wait_pixel(64, 10); chk("bar_blank", rgb(), 0);
        measure_hsync();
        iMode = 2'd2;

        // Frame 3: horizontal bands
        wait_pixel(3, 0);   chk("band0", rgb(), 0);
        wait_pixel(3, 6);   chk("band1_a", rgb(), 3'b001);
        wait_pixel(40, 6);  chk("band1_b", rgb(), 3'b001);
        wait_pixel(3, 42);  chk("band7", rgb(), 3'b111);
        wait_pixel(3, 48);  chk("band_blank", rgb(), 0);
        iMode = 2'd3;

        // Frame 4: checkerboard, then a one-Clock reset mid-frame
        wait_pixel(0, 0);
        wait_pixel(8, 0);   chk("chk_8_0", rgb(), 3'b111);
        wait_pixel(0, 6);   chk("chk_0_6", rgb(), 3'b111);
        wait_pixel(8, 6);   chk("chk_8_6", rgb(), 0);
        wait_pixel(48, 30); chk("chk_48_30", rgb(), 3'b111);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("mid_rst_col", int'(oCurrentCol), 0);
        chk("mid_rst_row", int'(oCurrentRow), 0);
        chk("mid_rst_rgb", rgb(), 0);
        chk("mid_rst_hs", int'(oHorizontal_Sync), 1);
        chk("mid_rst_vs", int'(oVertical_Sync), 1);

        // Disabled output: black, timing unchanged
        iEnable = 1'b0;
        wait_pixel(8, 0);   chk("dis_8_0", rgb(), 0);
        wait_pixel(68, 0);  chk("dis_hs_68", int'(oHorizontal_Sync), 0);
        measure_hsync();
        measure_frame();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
